hi_write_sequencer: RTL

- Host Interface master that walks an external command table and issues single-word register writes onto the HI device bus, with programmable delays between writes.
- Used for power-up and mode-change configuration of HI terminals without host software.
- Sits as one host port of the HI arbiter, alongside the USB/PC host.
- Holds the arbiter lock for the whole sequence so other hosts cannot interleave with it.

---
 rtl/hi_write_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hi_write_sequencer.sv
// HI bus master that walks an external command table and issues single-word
// register writes, with programmable delays, while holding the arbiter lock.
module hi_write_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned DELAY_W = 32
) (
    input  logic              ifclk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [81:0]       rom_data,
    output logic [15:0]       di_term_addr,
    output logic [31:0]       di_reg_addr,
    output logic [31:0]       di_len,
    output logic              di_write_mode,
    output logic              di_write,
    output logic [31:0]       di_reg_datai,
    input  logic              di_write_rdy,
    input  logic [15:0]       di_transfer_status,
    output logic [15:0]       last_status,
    output logic              lock_arbiter
);

    localparam int unsigned TCNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [15:0]         term_q;
    logic [31:0]         reg_q;
    logic [31:0]         data_q;
    logic [DELAY_W-1:0]  dcnt;
    logic [TCNT_W-1:0]   tcnt;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [15:0]         status_q;
    logic                done_q;
    logic [1:0]          rom_op;

    assign rom_op = rom_data[81:80];

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                unique case (rom_op)
                    2'd0: state_next = S_WRITE;
                    2'd1: state_next = (rom_data[DELAY_W-1:0] == '0) ? S_NEXT : S_DELAY;
                    2'd2: state_next = S_DONE;
                    default: state_next = S_ERROR;
                endcase
            end
            S_WRITE: begin
                if (di_write_rdy) begin
                    state_next = S_GAP;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    state_next = S_ERROR;
                end
            end
            S_GAP:   state_next = S_NEXT;
            S_DELAY: if (dcnt == '0) state_next = S_NEXT;
            S_NEXT:  state_next = (ptr == PTR_LAST) ? S_DONE : S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Delay counter loads data-1 so a delay of N spends exactly N cycles in DELAY.
    always_ff @(posedge ifclk) begin
        if (reset) begin
            ptr        <= '0;
            term_q     <= '0;
            reg_q      <= '0;
            data_q     <= '0;
            dcnt       <= '0;
            tcnt       <= '0;
            err_addr_q <= '0;
            status_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_next == S_DONE) && (state != S_DONE);
            unique case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) ptr <= '0;
                S_DECODE: begin
                    term_q <= rom_data[79:64];
                    reg_q  <= rom_data[63:32];
                    data_q <= rom_data[31:0];
                    dcnt   <= rom_data[DELAY_W-1:0] - DELAY_W'(1);
                    tcnt   <= '0;
                end
                S_WRITE: if (!di_write_rdy) tcnt <= tcnt + TCNT_W'(1);
                S_GAP:   status_q <= di_transfer_status;
                S_DELAY: if (dcnt != '0) dcnt <= dcnt - DELAY_W'(1);
                S_NEXT:  if (ptr != PTR_LAST) ptr <= ptr + ADDR_W'(1);
                default: ;
            endcase
            if ((state_next == S_ERROR) && (state != S_ERROR)) begin
                err_addr_q <= ptr;
            end
        end
    end

    // The only FETCH with ptr == 0 is the first one, which precedes the lock.
    always_comb begin
        busy          = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
        di_write_mode = (state == S_WRITE);
        di_write      = (state == S_WRITE) && di_write_rdy;
        error         = (state == S_ERROR);
        lock_arbiter  = busy && !((state == S_FETCH) && (ptr == '0));
    end

    assign done         = done_q;
    assign err_addr     = err_addr_q;
    assign rom_addr     = ptr;
    assign di_term_addr = term_q;
    assign di_reg_addr  = reg_q;
    assign di_reg_datai = data_q;
    assign di_len       = 32'd4;
    assign last_status  = status_q;

endmodule
